access_control_param: RTL and testbench

//  Parametrised password gate in front of the game datapath. The user selects an ID,

---
 rtl/access_control_param_pkg.sv | 30 +++
 rtl/access_control_param_if.sv | 40 ++++
 rtl/access_control_param_btn_edge_detect.sv | 28 ++
 rtl/access_control_param.sv | 197 +++++++++++++++++++
 tb/tb_access_control_param.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/access_control_param_pkg.sv
// ---------------------------------------------------------------------------
// access_control_param_pkg
// Shared definitions for the password gate:
//   state_t     - FSM state encodings (S_USER .. S_LOCK)
//   acp_clog2   - ceil(log2(value)), never below 1, for sizing derived widths
// ---------------------------------------------------------------------------
package access_control_param_pkg;

  typedef enum logic [2:0] {
    S_USER  = 3'd0,
    S_FETCH = 3'd1,
    S_DIGIT = 3'd2,
    S_CHECK = 3'd3,
    S_GRANT = 3'd4,
    S_FAIL  = 3'd5,
    S_LOCK  = 3'd6
  } state_t;

  // Minimum of 1 keeps every derived vector a legal width even for
  // degenerate parameter values such as NUM_USERS = 1.
  function automatic int acp_clog2(input int value);
    int w;
    w = 1;
    while ((32'sd1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/access_control_param_if.sv
// ---------------------------------------------------------------------------
// access_control_param_if
// UI and password-ROM signals of the access gate.
//   button_pulse  - enter button level (may be held)
//   toggle_switch - user ID / password digit
//   logout        - level, ends an authorised session
//   ld_in/ld_out  - load strobes before/after the authorisation gate
//   rom_addr/rom_q- synchronous password ROM port
//   green_led, red_led, locked, attempts - status outputs
// Modports: slave = the gate, master = the UI/ROM side.
// Widths must match the parameters of the attached access_control_param.
// ---------------------------------------------------------------------------
interface access_control_param_if #(
  parameter int DIGIT_W = 4,
  parameter int ADDR_W  = 4,
  parameter int NUM_LD  = 2,
  parameter int ATT_W   = 2
);
  logic               button_pulse;
  logic [DIGIT_W-1:0] toggle_switch;
  logic               logout;
  logic [NUM_LD-1:0]  ld_in;
  logic [DIGIT_W-1:0] rom_q;
  logic [ADDR_W-1:0]  rom_addr;
  logic [NUM_LD-1:0]  ld_out;
  logic               green_led;
  logic               red_led;
  logic               locked;
  logic [ATT_W-1:0]   attempts;

  modport slave (
    input  button_pulse, toggle_switch, logout, ld_in, rom_q,
    output rom_addr, ld_out, green_led, red_led, locked, attempts
  );

  modport master (
    output button_pulse, toggle_switch, logout, ld_in, rom_q,
    input  rom_addr, ld_out, green_led, red_led, locked, attempts
  );
endinterface

// File: rtl/access_control_param_btn_edge_detect.sv
// ---------------------------------------------------------------------------
// btn_edge_detect
// Turns a button level into a single-cycle pulse on its rising edge, so a
// held button counts as exactly one press.
//   clk      - system clock
//   rst      - asynchronous active-low reset
//   i_level  - raw button level
//   o_pulse  - high for the first cycle i_level is seen high
// ---------------------------------------------------------------------------
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_pulse
);
  logic r_level_d;

  // Delayed copy of the button level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= i_level;
    end
  end

  assign o_pulse = i_level & ~r_level_d;
endmodule

// File: rtl/access_control_param.sv
// ---------------------------------------------------------------------------
// access_control_param
// Password gate in front of the game datapath. A user ID is entered, then
// PW_LEN digits are compared against a synchronous password ROM. Success
// opens the load-strobe gate and lights green; failure lights red for
// FAIL_CYCLES, and MAX_ATTEMPTS consecutive failures lock the block out for
// LOCK_CYCLES.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - access_control_param_if.slave (UI inputs, ROM port, status)
// ---------------------------------------------------------------------------
module access_control_param
  import access_control_param_pkg::*;
#(
  parameter int DIGIT_W      = 4,
  parameter int PW_LEN       = 4,
  parameter int NUM_USERS    = 4,
  parameter int ROM_LAT      = 1,
  parameter int MAX_ATTEMPTS = 3,
  parameter int FAIL_CYCLES  = 8,
  parameter int LOCK_CYCLES  = 1024,
  parameter int NUM_LD       = 2
) (
  input logic                  clk,
  input logic                  rst,
  access_control_param_if.slave bus
);
  localparam int ADDR_W  = acp_clog2(NUM_USERS * PW_LEN);
  localparam int USER_W  = acp_clog2(NUM_USERS);
  localparam int ATT_W   = acp_clog2(MAX_ATTEMPTS + 1);
  localparam int IDX_W   = acp_clog2(PW_LEN);
  localparam int TMR_MAX = (LOCK_CYCLES > FAIL_CYCLES)
                         ? ((LOCK_CYCLES > ROM_LAT) ? LOCK_CYCLES : ROM_LAT)
                         : ((FAIL_CYCLES > ROM_LAT) ? FAIL_CYCLES : ROM_LAT);
  localparam int TMR_W   = acp_clog2(TMR_MAX);

  state_t              r_state, w_state_nxt;
  logic [USER_W-1:0]   r_uid, w_uid_nxt;
  logic                r_bad, w_bad_nxt;
  logic                r_mismatch, w_mismatch_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [ADDR_W-1:0]   r_rom_addr, w_rom_addr_nxt;
  logic [TMR_W-1:0]    r_timer, w_timer_nxt;
  logic [ATT_W-1:0]    r_attempts, w_attempts_nxt;
  logic                r_green, r_red, r_locked;
  logic                w_press;
  logic                w_id_out_of_range;

  btn_edge_detect u_btn (
    .clk     (clk),
    .rst     (rst),
    .i_level (bus.button_pulse),
    .o_pulse (w_press)
  );

  // The whole switch value is range-checked, so IDs whose low bits alias a
  // real user are still rejected; only the low bits address the ROM.
  assign w_id_out_of_range = (32'(bus.toggle_switch) >= 32'(NUM_USERS));

  // Next-state and datapath update for the entry/verdict FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_uid_nxt      = r_uid;
    w_bad_nxt      = r_bad;
    w_mismatch_nxt = r_mismatch;
    w_idx_nxt      = r_idx;
    w_rom_addr_nxt = r_rom_addr;
    w_timer_nxt    = r_timer;
    w_attempts_nxt = r_attempts;
    case (r_state)
      S_USER: begin
        if (w_press) begin
          w_uid_nxt      = bus.toggle_switch[USER_W-1:0];
          w_bad_nxt      = w_id_out_of_range;
          w_mismatch_nxt = 1'b0;
          w_idx_nxt      = '0;
          w_rom_addr_nxt = ADDR_W'(bus.toggle_switch[USER_W-1:0]) * ADDR_W'(PW_LEN);
          w_timer_nxt    = TMR_W'(ROM_LAT - 1);
          w_state_nxt    = S_FETCH;
        end else begin
          w_state_nxt = S_USER;
        end
      end
      S_FETCH: begin
        // rom_addr was registered on entry; wait out the ROM latency.
        if (r_timer == '0) begin
          w_state_nxt = S_DIGIT;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1'b1);
        end
      end
      S_DIGIT: begin
        if (w_press) begin
          // Accumulate rather than exit early so timing leaks nothing about
          // which digit was wrong.
          w_mismatch_nxt = r_mismatch | (bus.toggle_switch != bus.rom_q);
          if (r_idx == IDX_W'(PW_LEN - 1)) begin
            w_state_nxt = S_CHECK;
          end else begin
            w_idx_nxt      = r_idx + IDX_W'(1'b1);
            w_rom_addr_nxt = r_rom_addr + ADDR_W'(1'b1);
            w_timer_nxt    = TMR_W'(ROM_LAT - 1);
            w_state_nxt    = S_FETCH;
          end
        end else begin
          w_state_nxt = S_DIGIT;
        end
      end
      S_CHECK: begin
        if (!r_mismatch && !r_bad) begin
          w_attempts_nxt = '0;
          w_state_nxt    = S_GRANT;
        end else begin
          w_attempts_nxt = r_attempts + ATT_W'(1'b1);
          w_timer_nxt    = TMR_W'(FAIL_CYCLES - 1);
          w_state_nxt    = S_FAIL;
        end
      end
      S_GRANT: begin
        // A press arriving with logout is simply dropped.
        if (bus.logout) begin
          w_mismatch_nxt = 1'b0;
          w_bad_nxt      = 1'b0;
          w_state_nxt    = S_USER;
        end else begin
          w_state_nxt = S_GRANT;
        end
      end
      S_FAIL: begin
        if (r_timer == '0) begin
          if (r_attempts == ATT_W'(MAX_ATTEMPTS)) begin
            w_timer_nxt = TMR_W'(LOCK_CYCLES - 1);
            w_state_nxt = S_LOCK;
          end else begin
            w_mismatch_nxt = 1'b0;
            w_bad_nxt      = 1'b0;
            w_state_nxt    = S_USER;
          end
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1'b1);
        end
      end
      S_LOCK: begin
        if (r_timer == '0) begin
          w_attempts_nxt = '0;
          w_mismatch_nxt = 1'b0;
          w_bad_nxt      = 1'b0;
          w_state_nxt    = S_USER;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1'b1);
        end
      end
      default: begin
        w_state_nxt = S_USER;
      end
    endcase
  end

  // State, datapath and status registers; LEDs follow the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_USER;
      r_uid      <= '0;
      r_bad      <= 1'b0;
      r_mismatch <= 1'b0;
      r_idx      <= '0;
      r_rom_addr <= '0;
      r_timer    <= '0;
      r_attempts <= '0;
      r_green    <= 1'b0;
      r_red      <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_uid      <= w_uid_nxt;
      r_bad      <= w_bad_nxt;
      r_mismatch <= w_mismatch_nxt;
      r_idx      <= w_idx_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_timer    <= w_timer_nxt;
      r_attempts <= w_attempts_nxt;
      r_green    <= (w_state_nxt == S_GRANT);
      r_red      <= (w_state_nxt == S_FAIL) || (w_state_nxt == S_LOCK);
      r_locked   <= (w_state_nxt == S_LOCK);
    end
  end

  assign bus.rom_addr  = r_rom_addr;
  assign bus.green_led = r_green;
  assign bus.red_led   = r_red;
  assign bus.locked    = r_locked;
  assign bus.attempts  = r_attempts;
  // Load strobes pass straight through only while access is granted.
  assign bus.ld_out    = r_green ? bus.ld_in : '0;
endmodule

// File: tb/tb_access_control_param.sv
module tb_access_control_param;
  logic clk = 1'b0;
  logic rst = 1'b1;

  access_control_param_if #(.DIGIT_W(4), .ADDR_W(4), .NUM_LD(2), .ATT_W(2)) bus ();

  access_control_param #(
    .DIGIT_W(4), .PW_LEN(4), .NUM_USERS(4), .ROM_LAT(1), .MAX_ATTEMPTS(3),
    .FAIL_CYCLES(8), .LOCK_CYCLES(16), .NUM_LD(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Password ROM model, one cycle latency.
  logic [3:0] rom [16];
  always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

  typedef struct packed {
    logic       green;
    logic       red;
    logic [1:0] att;
    logic       locked;
    logic [1:0] ld;
  } verdict_t;

  verdict_t   verdict_q[$];
  logic [3:0] addr_q[$];
  int         red_len_q[$];
  logic [1:0] lock_rise_q[$];
  int         lock_len_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  function automatic verdict_t mk_v(input logic g, input logic r, input logic [1:0] a,
                                    input logic l, input logic [1:0] ld);
    verdict_t v;
    v.green = g; v.red = r; v.att = a; v.locked = l; v.ld = ld;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: DUT event with nothing expected at %0t", name, $time);
  endtask

  // Monitor: samples on the falling edge and pops expectations on DUT events.
  logic       prev_led = 1'b0;
  logic       prev_locked = 1'b0;
  logic [3:0] prev_addr = 4'd0;
  int         red_len = 0;
  int         lock_len = 0;
  verdict_t   mv;

  always @(negedge clk) begin
    if (!rst) begin
      prev_led    = 1'b0;
      prev_locked = 1'b0;
      prev_addr   = bus.rom_addr;
      red_len     = 0;
      lock_len    = 0;
    end else begin
      if (bus.rom_addr != prev_addr) begin
        if (addr_q.size() == 0) unexpected("rom_addr");
        else check("rom_addr", 32'(bus.rom_addr), 32'(addr_q.pop_front()));
      end
      prev_addr = bus.rom_addr;

      if ((bus.green_led || bus.red_led) && !prev_led) begin
        if (verdict_q.size() == 0) unexpected("verdict");
        else begin
          mv = verdict_q.pop_front();
          check("green_led", 32'(bus.green_led), 32'(mv.green));
          check("red_led",   32'(bus.red_led),   32'(mv.red));
          check("attempts",  32'(bus.attempts),  32'(mv.att));
          check("locked",    32'(bus.locked),    32'(mv.locked));
          check("ld_out",    32'(bus.ld_out),    32'(mv.ld));
        end
      end
      prev_led = bus.green_led || bus.red_led;

      if (bus.red_led) red_len++;
      else if (red_len != 0) begin
        if (red_len_q.size() == 0) unexpected("red_len");
        else check("red_len", 32'(red_len), 32'(red_len_q.pop_front()));
        red_len = 0;
      end

      if (bus.locked && !prev_locked) begin
        if (lock_rise_q.size() == 0) unexpected("lock_rise");
        else check("lock_rise_attempts", 32'(bus.attempts), 32'(lock_rise_q.pop_front()));
      end
      if (bus.locked) lock_len++;
      else if (lock_len != 0) begin
        if (lock_len_q.size() == 0) unexpected("lock_len");
        else begin
          check("lock_len", 32'(lock_len), 32'(lock_len_q.pop_front()));
          check("attempts_after_lock", 32'(bus.attempts), 32'd0);
        end
        lock_len = 0;
      end
      prev_locked = bus.locked;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] v, input int hold);
    bus.toggle_switch = v;
    bus.button_pulse  = 1'b1;
    cyc(hold);
    bus.button_pulse  = 1'b0;
    cyc(2);
  endtask

  // One ID + four digit entry; the verdict is queued only before the last
  // digit so an early verdict shows up as an unexpected event.
  task automatic session(input logic [3:0] id, input logic [15:0] digits, input int hold0,
                         input verdict_t v, input int exp_red, input bit exp_lock_rise,
                         input int exp_lock_len);
    logic [3:0] base;
    base = {id[1:0], 2'b00};
    for (int i = 0; i < 4; i++) addr_q.push_back(base + 4'(i));
    press(id, 1);
    for (int i = 0; i < 3; i++) press(digits[15-4*i -: 4], (i == 0) ? hold0 : 1);
    verdict_q.push_back(v);
    if (exp_red > 0) red_len_q.push_back(exp_red);
    if (exp_lock_rise) lock_rise_q.push_back(2'd3);
    if (exp_lock_len > 0) lock_len_q.push_back(exp_lock_len);
    press(digits[3:0], 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_green"},    32'(bus.green_led), 32'd0);
    check({tag, "_red"},      32'(bus.red_led),   32'd0);
    check({tag, "_locked"},   32'(bus.locked),    32'd0);
    check({tag, "_attempts"}, 32'(bus.attempts),  32'd0);
    check({tag, "_ld_out"},   32'(bus.ld_out),    32'd0);
    check({tag, "_rom_addr"}, 32'(bus.rom_addr),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rom = '{4'h9, 4'h9, 4'h9, 4'h9,  4'h1, 4'h1, 4'h0, 4'h1,
            4'h5, 4'h6, 4'h7, 4'h8,  4'h1, 4'h1, 4'h0, 4'h1};
    bus.button_pulse  = 1'b0;
    bus.toggle_switch = 4'd0;
    bus.logout        = 1'b0;
    bus.ld_in         = 2'b11;
    rst = 1'b0;
    #2;
    check_all_zero("reset");
    cyc(3);
    rst = 1'b1;
    cyc(2);

    // Correct password for user 1, then gate and logout behaviour.
    session(4'd1, 16'h1101, 1, mk_v(1'b1, 1'b0, 2'd0, 1'b0, 2'b11), 0, 1'b0, 0);
    cyc(2);
    bus.ld_in = 2'b10;
    #1;
    check("ld_out_passthrough", 32'(bus.ld_out), 32'h2);
    bus.ld_in = 2'b11;
    bus.logout = 1'b1;
    cyc(1);
    bus.logout = 1'b0;
    check("green_after_logout", 32'(bus.green_led), 32'd0);
    check("ld_after_logout",    32'(bus.ld_out),    32'd0);
    cyc(2);

    // First digit held for six cycles must count once; logout beats a press.
    session(4'd1, 16'h1101, 6, mk_v(1'b1, 1'b0, 2'd0, 1'b0, 2'b11), 0, 1'b0, 0);
    cyc(2);
    bus.toggle_switch = 4'd2;
    bus.logout        = 1'b1;
    bus.button_pulse  = 1'b1;
    cyc(1);
    bus.logout = 1'b0;
    cyc(3);
    bus.button_pulse = 1'b0;
    cyc(2);
    check("green_after_logout_press", 32'(bus.green_led), 32'd0);
    check("ld_after_logout_press",    32'(bus.ld_out),    32'd0);

    // Wrong digit, then out-of-range ID whose digits match, then lockout.
    session(4'd1, 16'h1111, 1, mk_v(1'b0, 1'b1, 2'd1, 1'b0, 2'b00), 8, 1'b0, 0);
    cyc(10);
    session(4'd7, 16'h1101, 1, mk_v(1'b0, 1'b1, 2'd2, 1'b0, 2'b00), 8, 1'b0, 0);
    cyc(10);
    session(4'd1, 16'h1111, 1, mk_v(1'b0, 1'b1, 2'd3, 1'b0, 2'b00), 24, 1'b1, 16);
    for (int i = 0; i < 6; i++) press(4'd2, 1);
    cyc(12);
    check("attempts_post_lock", 32'(bus.attempts), 32'd0);
    check("locked_post_lock",   32'(bus.locked),   32'd0);

    // Reset in the middle of a granted session.
    session(4'd1, 16'h1101, 1, mk_v(1'b1, 1'b0, 2'd0, 1'b0, 2'b11), 0, 1'b0, 0);
    cyc(2);
    #2 rst = 1'b0;
    #1;
    check_all_zero("rst_grant");
    cyc(2);
    rst = 1'b1;
    cyc(2);

    // Reset in the middle of a lockout.
    session(4'd1, 16'h1111, 1, mk_v(1'b0, 1'b1, 2'd1, 1'b0, 2'b00), 8, 1'b0, 0);
    cyc(10);
    session(4'd1, 16'h1111, 1, mk_v(1'b0, 1'b1, 2'd2, 1'b0, 2'b00), 8, 1'b0, 0);
    cyc(10);
    session(4'd1, 16'h1111, 1, mk_v(1'b0, 1'b1, 2'd3, 1'b0, 2'b00), 0, 1'b1, 0);
    cyc(14);
    check("locked_before_rst", 32'(bus.locked), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_all_zero("rst_lock");
    cyc(2);
    rst = 1'b1;
    cyc(2);

    // Failure count restarts from zero after the reset.
    session(4'd1, 16'h1111, 1, mk_v(1'b0, 1'b1, 2'd1, 1'b0, 2'b00), 8, 1'b0, 0);
    cyc(10);

    check("pending_addr",      32'(addr_q.size()),      32'd0);
    check("pending_verdict",   32'(verdict_q.size()),   32'd0);
    check("pending_red_len",   32'(red_len_q.size()),   32'd0);
    check("pending_lock_rise", 32'(lock_rise_q.size()), 32'd0);
    check("pending_lock_len",  32'(lock_len_q.size()),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
